// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
// Contents: mem_state_t FSM encoding, default bus widths, and mem_byte_sig codes.
// The package is named lc3b_types because the decode stage imports it under that name.
package lc3b_types;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // mem_byte_sig encodings from decode. Only MEM_BYTE is tested explicitly.
    // Every other value is treated as a word access.
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR    = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage controller (master) and the memory (slave).
// Signals: address, read/write strobes, byte mask and write data toward memory.
// Signals: read data and a one-cycle completion pulse (mem_resp) back from memory.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_byte_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_en, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_en, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_access_ctrl_byte_lane.sv
// mem_byte_lane: purely combinational byte-lane steering for a 2-lane (16-bit) data bus.
// Inputs:  i_addr0 = address bit 0, i_is_byte = byte access, i_wdata = store data, i_rdata = memory read data.
// Outputs: o_wdata = store data (replicated for bytes), o_byte_en = write mask, o_load_data = zero-extended load.
module mem_byte_lane #(
    parameter int DATA_W = 16
) (
    input  logic              i_addr0,
    input  logic              i_is_byte,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_wdata,
    output logic [1:0]        o_byte_en,
    output logic [DATA_W-1:0] o_load_data
);
    localparam int LANES = DATA_W / 8;

    always_comb begin
        o_wdata     = i_wdata;
        o_byte_en   = 2'b11;
        o_load_data = i_rdata;
        if (i_is_byte) begin
            // Put the byte on both lanes so memory picks it up whichever lane is enabled.
            o_wdata     = {LANES{i_wdata[7:0]}};
            o_byte_en   = i_addr0 ? 2'b10 : 2'b01;
            o_load_data = {{(DATA_W-8){1'b0}}, (i_addr0 ? i_rdata[15:8] : i_rdata[7:0])};
        end
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage sequencer for word/byte loads and stores and LDI/STI indirection.
// Ports: clk/reset, ctl_* decode control word, addr_in/wdata_in, mem_bus (master),
// rdata_out/done/stall toward writeback and pipeline control.
// Optional feature macro: MEM_ALIGN_CHECK_EN adds align_err and rejects odd word addresses.
// Without it, bit 0 is cleared on every word access.
module mem_access_ctrl
    import lc3b_types::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctl_valid,
    input  logic              ctl_read,
    input  logic              ctl_write,
    input  logic              ctl_indirect,
    input  logic [1:0]        ctl_byte,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    mem_access_ctrl_if.master mem_bus,
    output logic [DATA_W-1:0] rdata_out,
    output logic              done,
    output logic              stall
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              align_err
`endif
);

    mem_state_t        r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_is_read;
    logic              r_is_byte;
    logic              r_done;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic              r_align_err;
    logic              w_misalign;
`endif

    logic              w_mem_op;
    logic              w_launch;
    logic              w_launch_byte;
    logic              w_launch_rd;
    logic [ADDR_W-1:0] w_launch_addr;
    logic [DATA_W-1:0] w_lane_wdata;
    logic [DATA_W-1:0] w_lane_load;
    logic [1:0]        w_lane_be;

    assign w_mem_op = ctl_valid && (ctl_read || ctl_write);

    // The data access is launched from two places: straight out of IDLE for
    // direct ops, or from PTR once the pointer word returns.
    always_comb begin
        w_launch      = 1'b0;
        w_launch_addr = addr_in;
        w_launch_byte = 1'b0;
        w_launch_rd   = ctl_read;
        case (r_state)
            IDLE: begin
                w_launch      = w_mem_op && !ctl_indirect;
                w_launch_byte = (ctl_byte == MEM_BYTE);
            end
            PTR: begin
                w_launch      = mem_bus.mem_resp;
                w_launch_addr = ADDR_W'(mem_bus.mem_rdata);
                w_launch_rd   = r_is_read;
            end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = !w_launch_byte && w_launch_addr[0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mem_addr  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_is_read   <= 1'b0;
            r_is_byte   <= 1'b0;
            r_done      <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            r_align_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_align_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_mem_op) begin
                        // Read wins when decode sets both, so a store happens only without read.
                        r_is_read <= ctl_read;
                        r_is_byte <= (ctl_byte == MEM_BYTE) && !ctl_indirect;
                        r_wdata   <= wdata_in;
                        if (ctl_indirect) begin
                            r_mem_addr  <= {addr_in[ADDR_W-1:1], 1'b0};
                            r_mem_read  <= 1'b1;
                            r_mem_write <= 1'b0;
                            r_state     <= PTR;
                        end
                    end
                end
                PTR: ;
                ACCESS: begin
                    if (mem_bus.mem_resp) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_is_read) begin
                            r_rdata <= w_lane_load;
                        end
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // Placed after the case so it overrides the PTR hold and the IDLE capture.
            if (w_launch) begin
`ifdef MEM_ALIGN_CHECK_EN
                if (w_misalign) begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_rdata     <= '0;
                    r_done      <= 1'b1;
                    r_align_err <= 1'b1;
                    r_state     <= DONE;
                end else
`endif
                begin
                    r_mem_addr  <= w_launch_byte ? w_launch_addr
                                                 : {w_launch_addr[ADDR_W-1:1], 1'b0};
                    r_mem_read  <= w_launch_rd;
                    r_mem_write <= !w_launch_rd;
                    r_state     <= ACCESS;
                end
            end
        end
    end

    mem_byte_lane #(.DATA_W(DATA_W)) u_byte_lane (
        .i_addr0     (r_mem_addr[0]),
        .i_is_byte   (r_is_byte),
        .i_wdata     (r_wdata),
        .i_rdata     (mem_bus.mem_rdata),
        .o_wdata     (w_lane_wdata),
        .o_byte_en   (w_lane_be),
        .o_load_data (w_lane_load)
    );

    assign mem_bus.mem_address = r_mem_addr;
    assign mem_bus.mem_read    = r_mem_read;
    assign mem_bus.mem_write   = r_mem_write;
    assign mem_bus.mem_wdata   = r_mem_write ? w_lane_wdata : '0;
    assign mem_bus.mem_byte_en = (r_mem_read || r_mem_write) ? w_lane_be : 2'b00;

    assign rdata_out = r_rdata;
    assign done      = r_done;
    // Stall asserts in the IDLE cycle that accepts the op, so the op is held before any state changes.
    assign stall     = (r_state == PTR) || (r_state == ACCESS) || ((r_state == IDLE) && w_mem_op);
`ifdef MEM_ALIGN_CHECK_EN
    assign align_err = r_align_err;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases followed by random ops.
// The memory is a word-addressed sparse array with a programmable response delay.
// A separate reference memory predicts load results, stores, access order and stall length.
module tb_mem_access_ctrl;
    import lc3b_types::*;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctl_valid, ctl_read, ctl_write, ctl_indirect;
    logic [1:0]  ctl_byte;
    logic [15:0] addr_in, wdata_in;
    logic [15:0] rdata_out;
    logic        done, stall;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] mem     [int];
    logic [15:0] ref_mem [int];
    acc_t        log_q[$];
    int          mem_dly = 0;
    int          mem_cnt = 0;
    bit          stray_en = 1'b0;
    int          mw;
    logic [15:0] mv;
    logic [15:0] model_rdata = 16'h0;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .ctl_valid    (ctl_valid),
        .ctl_read     (ctl_read),
        .ctl_write    (ctl_write),
        .ctl_indirect (ctl_indirect),
        .ctl_byte     (ctl_byte),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .mem_bus      (bus),
        .rdata_out    (rdata_out),
        .done         (done),
        .stall        (stall)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .align_err    (align_err)
`endif
    );

    function automatic logic [15:0] dflt(int w);
        return 16'((w * 40503) ^ 23100);
    endfunction

    function automatic logic [15:0] mem_rd(int w);
        return mem.exists(w) ? mem[w] : dflt(w);
    endfunction

    function automatic logic [15:0] ref_rd(int w);
        return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
    endfunction

    // Memory model. It answers a request after mem_dly extra cycles. Between
    // responses it drives garbage read data and, if enabled, stray responses.
    always @(negedge clk) begin
        if (bus.mem_read || bus.mem_write) begin
            if (mem_cnt >= mem_dly) begin
                mw = int'(bus.mem_address >> 1);
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = mem_rd(mw);
                if (bus.mem_write) begin
                    mv = mem_rd(mw);
                    if (bus.mem_byte_en[0]) mv[7:0]  = bus.mem_wdata[7:0];
                    if (bus.mem_byte_en[1]) mv[15:8] = bus.mem_wdata[15:8];
                    mem[mw] = mv;
                end
                log_q.push_back({bus.mem_write, bus.mem_address, bus.mem_byte_en, bus.mem_wdata});
                mem_cnt = 0;
            end else begin
                bus.mem_resp  = 1'b0;
                bus.mem_rdata = 16'($urandom);
                mem_cnt++;
            end
        end else begin
            bus.mem_resp  = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata = 16'($urandom);
            mem_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        mem[int'(a >> 1)]     = v;
        ref_mem[int'(a >> 1)] = v;
    endtask

    // Run one memory op and check the result against the reference model.
    task automatic do_op(input logic rd, input logic wr, input logic ind, input logic [1:0] bsig,
                         input logic [15:0] addr, input logic [15:0] wd, input int dly,
                         output logic [15:0] got);
        logic        eff_byte;
        logic [15:0] fin, val, exp_rd, exp_wd, cur;
        logic [1:0]  exp_be;
        int          stalls, exp_stall;
        bit          seen;
        acc_t        exp_acc[$];

        eff_byte = (bsig == 2'b01) && !ind;
        exp_acc  = {};
        exp_wd   = 16'h0;
        exp_be   = 2'b11;
        if (ind) begin
            exp_acc.push_back({1'b0, addr & 16'hFFFE, 2'b11, 16'h0});
            fin = ref_rd(int'(addr >> 1)) & 16'hFFFE;
        end else begin
            fin = eff_byte ? addr : (addr & 16'hFFFE);
        end
        if (rd) begin
            val    = ref_rd(int'(fin >> 1));
            exp_rd = !eff_byte ? val : (fin[0] ? {8'h00, val[15:8]} : {8'h00, val[7:0]});
            exp_acc.push_back({1'b0, fin, 2'b11, 16'h0});
        end else begin
            exp_rd = model_rdata;
            exp_wd = eff_byte ? {wd[7:0], wd[7:0]} : wd;
            exp_be = eff_byte ? (fin[0] ? 2'b10 : 2'b01) : 2'b11;
            cur    = ref_rd(int'(fin >> 1));
            if (exp_be[0]) cur[7:0]  = exp_wd[7:0];
            if (exp_be[1]) cur[15:8] = exp_wd[15:8];
            ref_mem[int'(fin >> 1)] = cur;
            exp_acc.push_back({1'b1, fin, exp_be, exp_wd});
        end
        model_rdata = exp_rd;
        exp_stall   = 1 + exp_acc.size() * (dly + 1);

        log_q   = {};
        mem_dly = dly;
        @(posedge clk);
        #1;
        ctl_valid = 1'b1; ctl_read = rd; ctl_write = wr; ctl_indirect = ind;
        ctl_byte = bsig; addr_in = addr; wdata_in = wd;
        stalls = 0;
        seen   = 1'b0;
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk("stall_in_done", 32'(stall), 32'd0);
            end else if (stall) begin
                stalls++;
            end
        end
        ctl_valid = 1'b0; ctl_read = 1'b0; ctl_write = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        chk("rdata_out", 32'(rdata_out), 32'(exp_rd));
        chk("n_access", 32'(log_q.size()), 32'(exp_acc.size()));
        for (int i = 0; i < exp_acc.size() && i < log_q.size(); i++) begin
            chk("acc_wr", 32'(log_q[i].wr), 32'(exp_acc[i].wr));
            chk("acc_addr", 32'(log_q[i].addr), 32'(exp_acc[i].addr));
            if (exp_acc[i].wr || !eff_byte) chk("acc_be", 32'(log_q[i].be), 32'(exp_acc[i].be));
            if (exp_acc[i].wr) chk("acc_wdata", 32'(log_q[i].wdata), 32'(exp_acc[i].wdata));
        end
        if (!rd) chk("mem_after_store", 32'(mem_rd(int'(fin >> 1))), 32'(ref_rd(int'(fin >> 1))));
        got = rdata_out;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] got;
        logic        r_rd, r_wr, r_ind;

        reset = 1'b1; ctl_valid = 1'b0; ctl_read = 1'b0; ctl_write = 1'b0;
        ctl_indirect = 1'b0; ctl_byte = 2'b11; addr_in = 16'h0; wdata_in = 16'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst_byte_en", 32'(bus.mem_byte_en), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_rdata_out", 32'(rdata_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // LDR word, two-cycle memory, stall is four cycles.
        poke(16'h1000, 16'hBEEF);
        do_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h1000, 16'h0, 2, got);
        chk("ldr_lit", 32'(got), 32'h0000BEEF);

        // LDB high and low byte.
        poke(16'h2000, 16'h12AB);
        do_op(1'b1, 1'b0, 1'b0, 2'b01, 16'h2001, 16'h0, 1, got);
        chk("ldb_hi_lit", 32'(got), 32'h00000012);
        do_op(1'b1, 1'b0, 1'b0, 2'b01, 16'h2000, 16'h0, 0, got);
        chk("ldb_lo_lit", 32'(got), 32'h000000AB);

        // STB to odd address; rdata_out must keep the previous load result.
        do_op(1'b0, 1'b1, 1'b0, 2'b01, 16'h3001, 16'h5566, 1, got);
        chk("stb_wdata_lit", 32'(log_q[0].wdata), 32'h00006666);
        chk("stb_be_lit", 32'(log_q[0].be), 32'd2);
        chk("stb_rdata_kept", 32'(got), 32'h000000AB);

        // LDI, then STI through the same pointer.
        poke(16'h4000, 16'h5000);
        poke(16'h5000, 16'h0042);
        do_op(1'b1, 1'b0, 1'b1, 2'b11, 16'h4000, 16'h0, 1, got);
        chk("ldi_lit", 32'(got), 32'h00000042);
        chk("ldi_second_addr", 32'(log_q[1].addr), 32'h00005000);
        do_op(1'b0, 1'b1, 1'b1, 2'b11, 16'h4000, 16'h1234, 0, got);
        chk("sti_addr", 32'(log_q[1].addr), 32'h00005000);
        chk("sti_data", 32'(mem_rd(int'(16'h5000 >> 1))), 32'h00001234);

        // Read and write together: read wins.
        do_op(1'b1, 1'b1, 1'b0, 2'b11, 16'h5000, 16'hFFFF, 0, got);
        chk("rw_read_wins", 32'(got), 32'h00001234);

        // Word access at an odd address has bit 0 cleared.
        do_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h1001, 16'h0, 0, got);

        // A non-memory instruction passes through without a stall.
        @(posedge clk); #1;
        ctl_valid = 1'b1;
        @(negedge clk);
        chk("nonmem_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("nonmem_read", 32'(bus.mem_read), 32'd0);
        chk("nonmem_done", 32'(done), 32'd0);
        ctl_valid = 1'b0;

        // Reset in ACCESS before mem_resp abandons the transaction.
        mem_dly = 8;
        @(posedge clk); #1;
        ctl_valid = 1'b1; ctl_read = 1'b1; ctl_write = 1'b0; ctl_indirect = 1'b0;
        ctl_byte = 2'b11; addr_in = 16'h1000;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_read", 32'(bus.mem_read), 32'd1);
        reset = 1'b1; ctl_valid = 1'b0; ctl_read = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_read", 32'(bus.mem_read), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_rdata", 32'(rdata_out), 32'd0);
        model_rdata = 16'h0;
        do_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h1000, 16'h0, 0, got);
        chk("post_rst_ldr", 32'(got), 32'h0000BEEF);

        // Random ops over a small region with stray responses while idle.
        stray_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            r_rd  = 1'($urandom_range(0, 1));
            r_wr  = r_rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            r_ind = ($urandom_range(0, 3) == 0);
            do_op(r_rd, r_wr, r_ind, 2'($urandom_range(0, 3)),
                  {10'h180, 6'($urandom_range(0, 63))}, 16'($urandom),
                  $urandom_range(0, 3), got);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                ctl_valid = 1'b1;
                @(negedge clk);
                chk("rand_nonmem_stall", 32'(stall), 32'd0);
                ctl_valid = 1'b0;
            end
        end
        stray_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
